// File: rtl/regfile_checker.sv
// End-of-test checker: shadows writeback into a register file, detects halt/timeout,
// then compares each shadow register against a golden ROM and reports tallies.
module regfile_checker #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int PC_W         = 32,
    parameter int HALT_CYCLES  = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    localparam int IDX_W       = $clog2(NREGS),
    localparam int CNT_W       = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc_f,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             gold_rd_en,
    output logic [IDX_W-1:0] gold_addr,
    input  logic [XLEN-1:0]  gold_data,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [31:0]      cycle_count
);

    localparam int ST_W = $clog2(HALT_CYCLES);
    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PC_W-1:0]  pc_prev;
    logic [ST_W-1:0]  stable_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic [CNT_W-1:0] rd_idx;
    logic             cmp_vld;
    logic [IDX_W-1:0] cmp_idx;
    logic [XLEN-1:0]  shadow [NREGS];

    logic             pc_eq;
    logic             halt;
    logic             limit;
    logic             drain_last;
    logic             check_last;
    logic             capture;

    assign pc_eq      = (pc_f == pc_prev);
    assign halt       = (state == S_RUN) && pc_eq && (stable_cnt == ST_W'(HALT_CYCLES - 1));
    assign limit      = (state == S_RUN) && (cycle_count == 32'(MAX_CYCLES - 1));
    assign drain_last = (drain_cnt == DR_W'(DRAIN_CYCLES - 1));
    assign check_last = (rd_idx == CNT_W'(NREGS));
    assign capture    = ((state == S_RUN) || (state == S_DRAIN)) && wb_en && (wb_rd != '0);

    // x0 is hard-wired; every other entry is a plain write-enabled register
    for (genvar g = 0; g < NREGS; g++) begin : g_shadow
        if (g == 0) begin : g_zero
            assign shadow[g] = '0;
        end else begin : g_reg
            logic [XLEN-1:0] q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (capture && (wb_rd == IDX_W'(g))) begin
                    q <= wb_data;
                end
            end
            assign shadow[g] = q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gold_rd_en = 1'b0;
        gold_addr  = '0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            S_RUN: begin
                // halt takes priority over the cycle limit when both fire together
                if (halt) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
                end else if (limit) begin
                    state_nxt = S_CHECK;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!check_last) begin
                    gold_rd_en = 1'b1;
                    gold_addr  = rd_idx[IDX_W-1:0];
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                pass = (fail_count == '0) && !timeout;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_prev          <= '0;
            stable_cnt       <= '0;
            cycle_count      <= '0;
            timeout          <= 1'b0;
            drain_cnt        <= '0;
            rd_idx           <= '0;
            cmp_vld          <= 1'b0;
            cmp_idx          <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            cmp_vld <= gold_rd_en;
            cmp_idx <= gold_addr;

            if (state == S_RUN) begin
                pc_prev     <= pc_f;
                stable_cnt  <= pc_eq ? stable_cnt + ST_W'(1) : '0;
                cycle_count <= cycle_count + 32'd1;
                if (limit && !halt) begin
                    timeout <= 1'b1;
                end
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DR_W'(1);
            end

            if ((state == S_CHECK) && !check_last) begin
                rd_idx <= rd_idx + CNT_W'(1);
            end

            // golden data arrives one cycle after its read strobe
            if (cmp_vld) begin
                if (gold_data == shadow[cmp_idx]) begin
                    pass_count <= pass_count + CNT_W'(1);
                end else begin
                    fail_count <= fail_count + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= cmp_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_checker.sv
// Scoreboard bench for regfile_checker: per-run expectations queued at stimulus time, popped on done.
module tb_regfile_checker;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;
    localparam int HALT  = 8;
    localparam int DRAIN = 4;
    localparam int MAXC  = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc_f;
    logic             wb_en;
    logic [IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             gold_rd_en;
    logic [IDX_W-1:0] gold_addr;
    logic [XLEN-1:0]  gold_data = '0;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic             first_fail_valid;
    logic [IDX_W-1:0] first_fail_idx;
    logic [31:0]      cycle_count;

    regfile_checker #(
        .XLEN(XLEN), .NREGS(NREGS), .PC_W(32),
        .HALT_CYCLES(HALT), .DRAIN_CYCLES(DRAIN), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .gold_rd_en(gold_rd_en), .gold_addr(gold_addr), .gold_data(gold_data),
        .done(done), .pass(pass), .timeout(timeout),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] gold_mem [NREGS];

    // golden ROM: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (gold_rd_en) gold_data <= gold_mem[gold_addr];
    end

    typedef struct {
        int          cyc;
        int          rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int done_cyc;
        int pass;
        int pass_count;
        int fail_count;
        int ffv;
        int ffi;
        int timeout;
        int cycle_count;
    } exp_t;

    wr_t  wr_q[$];
    exp_t exp_q[$];
    int   addr_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        wr_q.delete();
        for (int i = 0; i < NREGS; i++) gold_mem[i] = '0;
    endtask

    task automatic add_wr(input int cyc, input int rd, input logic [31:0] data);
        wr_t w;
        w.cyc = cyc; w.rd = rd; w.data = data;
        wr_q.push_back(w);
    endtask

    // halt_at: first cycle whose PC equals the previous one (-1: PC never stalls)
    // abort_at: cycle at which the run is abandoned and the next reset hits mid-flight
    task automatic run_test(input string name, input int halt_at, input int abort_at);
        exp_t        e;
        exp_t        r;
        int          cs;
        int          ncmp;
        int          idle_bad;
        bit          seen_done;
        bit          first_rd;
        logic [31:0] sh [NREGS];

        if (halt_at >= 0) begin
            cs            = halt_at + HALT - 1 + 1 + DRAIN;
            e.cycle_count = halt_at + HALT;
            e.timeout     = 0;
        end else begin
            cs            = MAXC;
            e.cycle_count = MAXC;
            e.timeout     = 1;
        end
        e.done_cyc = cs + NREGS + 1;
        for (int i = 0; i < NREGS; i++) sh[i] = '0;
        foreach (wr_q[i]) if (wr_q[i].cyc < cs && wr_q[i].rd != 0) sh[wr_q[i].rd] = wr_q[i].data;
        e.pass_count = 0; e.fail_count = 0; e.ffv = 0; e.ffi = 0;
        for (int i = 0; i < NREGS; i++) begin
            if (sh[i] == gold_mem[i]) e.pass_count++;
            else begin
                if (e.ffv == 0) begin e.ffv = 1; e.ffi = i; end
                e.fail_count++;
            end
        end
        e.pass = (e.fail_count == 0 && e.timeout == 0) ? 1 : 0;
        exp_q.push_back(e);
        addr_q.delete();
        for (int i = 0; i < NREGS; i++) addr_q.push_back(i);

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        seen_done = 0; first_rd = 1; idle_bad = 0;
        for (int cyc = 0; cyc <= e.done_cyc + 6; cyc++) begin
            pc_f    = (halt_at >= 0 && cyc >= halt_at - 1) ? 32'h40 : 32'h100 + 32'(4 * cyc);
            wb_en   = 1'b0; wb_rd = '0; wb_data = '0;
            foreach (wr_q[i]) begin
                if (wr_q[i].cyc == cyc) begin
                    wb_en = 1'b1; wb_rd = wr_q[i].rd[IDX_W-1:0]; wb_data = wr_q[i].data;
                end
            end
            @(negedge clk);
            if (cyc == 0) begin
                chk_eq({name, ".rst_done"}, done, 0);
                chk_eq({name, ".rst_pass"}, pass, 0);
                chk_eq({name, ".rst_pcnt"}, pass_count, 0);
                chk_eq({name, ".rst_fcnt"}, fail_count, 0);
                chk_eq({name, ".rst_ffv"}, first_fail_valid, 0);
                chk_eq({name, ".rst_tmo"}, timeout, 0);
                chk_eq({name, ".rst_cyc"}, cycle_count, 0);
                chk_eq({name, ".rst_rden"}, gold_rd_en, 0);
            end
            if (cyc == 1) chk_eq({name, ".cyc1"}, cycle_count, 1);
            if (cyc == abort_at) begin
                ncmp = abort_at - cs - 1;
                r = exp_q.pop_front();
                chk_eq({name, ".abort_done"}, done, 0);
                chk_eq({name, ".abort_pcnt"}, pass_count, 64'(ncmp));
                return;
            end
            if (gold_rd_en) begin
                if (first_rd) chk_eq({name, ".rd_start"}, cyc, cs);
                first_rd = 0;
                if (addr_q.size() == 0) chk_eq({name, ".extra_rd"}, 1, 0);
                else chk_eq({name, ".gold_addr"}, gold_addr, addr_q.pop_front());
            end else if (gold_addr != '0) begin
                idle_bad++;
            end
            if (done && !seen_done) begin
                seen_done = 1;
                r = exp_q.pop_front();
                chk_eq({name, ".done_cyc"}, cyc, r.done_cyc);
                chk_eq({name, ".pass"}, pass, r.pass);
                chk_eq({name, ".pass_count"}, pass_count, r.pass_count);
                chk_eq({name, ".fail_count"}, fail_count, r.fail_count);
                chk_eq({name, ".ffv"}, first_fail_valid, r.ffv);
                if (r.ffv != 0) chk_eq({name, ".ffi"}, first_fail_idx, r.ffi);
                chk_eq({name, ".timeout"}, timeout, r.timeout);
                chk_eq({name, ".cycle_count"}, cycle_count, r.cycle_count);
            end
            @(posedge clk);
            #1;
        end
        if (!seen_done) begin
            chk_eq({name, ".done_seen"}, 0, 1);
            r = exp_q.pop_front();
        end
        chk_eq({name, ".done_sticky"}, done, 1);
        chk_eq({name, ".reads_left"}, addr_q.size(), 0);
        chk_eq({name, ".idle_addr"}, idle_bad, 0);
    endtask

    initial begin
        rst = 1'b1; pc_f = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;

        clear_stim();
        add_wr(2, 1, 32'h3); add_wr(3, 1, 32'h5); add_wr(4, 2, 32'hA);
        gold_mem[1] = 32'h5; gold_mem[2] = 32'hA;
        run_test("halt_pass", 20, -1);

        clear_stim();
        add_wr(3, 1, 32'h5); add_wr(4, 2, 32'hA);
        gold_mem[1] = 32'h5; gold_mem[2] = 32'hA; gold_mem[5] = 32'h7;
        run_test("x5_mismatch", 20, -1);

        clear_stim();
        add_wr(5, 0, 32'hDEAD); add_wr(6, 7, 32'h77);
        gold_mem[7] = 32'h77;
        run_test("x0_write", 20, -1);

        clear_stim();
        add_wr(10, 9, 32'h99);
        gold_mem[9] = 32'h99;
        run_test("timeout", -1, -1);

        clear_stim();
        add_wr(30, 3, 32'h33); add_wr(34, 4, 32'h44);
        gold_mem[3] = 32'h33;
        run_test("drain_wr", 20, -1);

        clear_stim();
        add_wr(2, 1, 32'h5); add_wr(8, 31, 32'hCAFE);
        gold_mem[1] = 32'h5; gold_mem[31] = 32'hCAFE;
        run_test("abort", 20, 42);
        run_test("after_abort", 20, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
